// File: rtl/wr_dec_balance_mon.sv
// Multi-channel monitor pairing each write-enable pulse with one unit decrement of
// that channel's remaining-words counter; sticky errors plus first-error capture.
module wr_dec_balance_mon #(
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 14,
    parameter int LAG_TOL = 2,
    parameter int LAG_CYC = 8,
    parameter int STAT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mon_en,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*CNT_W-1:0]  left_cnt,
    output logic [NUM_CH*STAT_W-1:0] wr_cnt,
    output logic [NUM_CH*STAT_W-1:0] dec_cnt,
    output logic [NUM_CH-1:0]        err_vec,
    output logic                     first_err_vld,
    output logic [$clog2(NUM_CH):0]  first_err_ch,
    output logic [1:0]               first_err_code,
    output logic [STAT_W-1:0]        first_err_cyc
);
    localparam int BAL_W = $clog2(LAG_TOL + 1) + 2;
    localparam int TMR_W = $clog2(LAG_CYC + 1);
    localparam int CH_W  = $clog2(NUM_CH) + 1;

    localparam logic signed [BAL_W-1:0] BAL_MAX = {1'b0, {(BAL_W-1){1'b1}}};
    localparam logic signed [BAL_W-1:0] BAL_MIN = {1'b1, {(BAL_W-1){1'b0}}};
    localparam logic signed [BAL_W-1:0] BAL_ONE = {{(BAL_W-1){1'b0}}, 1'b1};
    localparam logic signed [BAL_W-1:0] TOL_POS = BAL_W'(LAG_TOL);
    localparam logic signed [BAL_W-1:0] TOL_NEG = -TOL_POS;
    localparam logic [TMR_W-1:0]        TMR_LIM = TMR_W'(LAG_CYC);

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_IMBAL = 2'd1,
        ERR_JUMP  = 2'd2,
        ERR_STALE = 2'd3
    } err_code_e;

    logic [CNT_W-1:0]        r_prev     [NUM_CH];
    logic [NUM_CH-1:0]       r_prev_vld;
    logic signed [BAL_W-1:0] r_bal      [NUM_CH];
    logic [TMR_W-1:0]        r_tmr      [NUM_CH];
    logic [STAT_W-1:0]       r_wr_cnt   [NUM_CH];
    logic [STAT_W-1:0]       r_dec_cnt  [NUM_CH];
    logic [NUM_CH-1:0]       r_err;
    logic                    r_first_vld;
    logic [CH_W-1:0]         r_first_ch;
    err_code_e               r_first_code;
    logic [STAT_W-1:0]       r_first_cyc;
    logic [STAT_W-1:0]       r_cyc;

    logic [CNT_W-1:0]        w_cur      [NUM_CH];
    logic [NUM_CH-1:0]       w_reload;
    logic [NUM_CH-1:0]       w_dec;
    logic [NUM_CH-1:0]       w_jump;
    logic signed [BAL_W-1:0] w_bal_base [NUM_CH];
    logic signed [BAL_W-1:0] w_bal_nxt  [NUM_CH];
    logic [TMR_W-1:0]        w_tmr_nxt  [NUM_CH];
    err_code_e               w_code     [NUM_CH];
    logic [NUM_CH-1:0]       w_err_hit;
    logic                    w_any_err;
    logic [CH_W-1:0]         w_sel_ch;
    err_code_e               w_sel_code;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_cur[ch]      = left_cnt[ch*CNT_W +: CNT_W];
            w_reload[ch]   = r_prev_vld[ch] && (w_cur[ch] > r_prev[ch]);
            w_dec[ch]      = r_prev_vld[ch] && (r_prev[ch] > w_cur[ch])
                             && (w_cur[ch] + CNT_W'(1) == r_prev[ch]);
            w_jump[ch]     = r_prev_vld[ch] && (r_prev[ch] > w_cur[ch]) && !w_dec[ch];
            // A reload wipes the balance before this cycle's write/decrement apply.
            w_bal_base[ch] = w_reload[ch] ? '0 : r_bal[ch];

            // NOTE: every combinational variable gets a default before any branch so no latch is inferred.
            w_bal_nxt[ch] = w_bal_base[ch];
            if (wr_en[ch] && !w_dec[ch] && w_bal_base[ch] != BAL_MAX)
                w_bal_nxt[ch] = w_bal_base[ch] + BAL_ONE;
            else if (w_dec[ch] && !wr_en[ch] && w_bal_base[ch] != BAL_MIN)
                w_bal_nxt[ch] = w_bal_base[ch] - BAL_ONE;

            w_tmr_nxt[ch] = r_tmr[ch];
            if (w_reload[ch] || w_bal_nxt[ch] == '0)
                w_tmr_nxt[ch] = '0;
            else if (w_bal_base[ch] != '0 && r_tmr[ch] != TMR_LIM)
                w_tmr_nxt[ch] = r_tmr[ch] + TMR_W'(1);

            w_code[ch] = ERR_NONE;
            if (w_jump[ch])
                w_code[ch] = ERR_JUMP;
            else if (w_bal_nxt[ch] > TOL_POS || w_bal_nxt[ch] < TOL_NEG)
                w_code[ch] = ERR_IMBAL;
            else if (w_tmr_nxt[ch] == TMR_LIM)
                w_code[ch] = ERR_STALE;
            w_err_hit[ch] = (w_code[ch] != ERR_NONE);
        end
    end

    // Scan downward so the lowest failing channel is the one left standing.
    always_comb begin
        w_sel_ch   = '0;
        w_sel_code = ERR_NONE;
        for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
            if (w_err_hit[ch]) begin
                w_sel_ch   = CH_W'(ch);
                w_sel_code = w_code[ch];
            end
        end
    end

    assign w_any_err = |w_err_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the per-channel arrays are plain flops, not RAM, so they are cleared with everything else.
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_prev[ch]    <= '0;
                r_bal[ch]     <= '0;
                r_tmr[ch]     <= '0;
                r_wr_cnt[ch]  <= '0;
                r_dec_cnt[ch] <= '0;
            end
            r_prev_vld   <= '0;
            r_err        <= '0;
            r_first_vld  <= 1'b0;
            r_first_ch   <= '0;
            r_first_code <= ERR_NONE;
            r_first_cyc  <= '0;
            r_cyc        <= '0;
        end else if (clr) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_prev[ch]    <= '0;
                r_bal[ch]     <= '0;
                r_tmr[ch]     <= '0;
                r_wr_cnt[ch]  <= '0;
                r_dec_cnt[ch] <= '0;
            end
            r_prev_vld   <= '0;
            r_err        <= '0;
            r_first_vld  <= 1'b0;
            r_first_ch   <= '0;
            r_first_code <= ERR_NONE;
            r_first_cyc  <= '0;
            r_cyc        <= '0;
        end else if (mon_en) begin
            // NOTE: state updates are non-blocking; all next values were settled combinationally above.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_prev[ch] <= w_cur[ch];
                r_bal[ch]  <= w_bal_nxt[ch];
                r_tmr[ch]  <= w_tmr_nxt[ch];
                if (wr_en[ch] && r_wr_cnt[ch] != '1)
                    r_wr_cnt[ch] <= r_wr_cnt[ch] + STAT_W'(1);
                if (w_dec[ch] && r_dec_cnt[ch] != '1)
                    r_dec_cnt[ch] <= r_dec_cnt[ch] + STAT_W'(1);
            end
            r_prev_vld <= '1;
            r_err      <= r_err | w_err_hit;
            r_cyc      <= r_cyc + STAT_W'(1);
            if (!r_first_vld && w_any_err) begin
                r_first_vld  <= 1'b1;
                r_first_ch   <= w_sel_ch;
                r_first_code <= w_sel_code;
                r_first_cyc  <= r_cyc;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat_out
        assign wr_cnt[g*STAT_W +: STAT_W]  = r_wr_cnt[g];
        assign dec_cnt[g*STAT_W +: STAT_W] = r_dec_cnt[g];
    end

    assign err_vec        = r_err;
    assign first_err_vld  = r_first_vld;
    assign first_err_ch   = r_first_ch;
    assign first_err_code = r_first_code;
    assign first_err_cyc  = r_first_cyc;

endmodule

// File: tb/tb_wr_dec_balance_mon.sv
// Scoreboard bench for wr_dec_balance_mon: directed scenarios plus randomized traffic,
// each cycle's expectation produced by an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_wr_dec_balance_mon;
    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 14;
    localparam int LAG_TOL = 2;
    localparam int LAG_CYC = 8;
    localparam int STAT_W  = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     mon_en;
    logic                     clr;
    logic [NUM_CH-1:0]        wr_en;
    logic [NUM_CH*CNT_W-1:0]  left_cnt;
    logic [NUM_CH*STAT_W-1:0] wr_cnt;
    logic [NUM_CH*STAT_W-1:0] dec_cnt;
    logic [NUM_CH-1:0]        err_vec;
    logic                     first_err_vld;
    logic [2:0]               first_err_ch;
    logic [1:0]               first_err_code;
    logic [STAT_W-1:0]        first_err_cyc;

    wr_dec_balance_mon #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LAG_TOL(LAG_TOL), .LAG_CYC(LAG_CYC), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr),
        .wr_en(wr_en), .left_cnt(left_cnt),
        .wr_cnt(wr_cnt), .dec_cnt(dec_cnt), .err_vec(err_vec),
        .first_err_vld(first_err_vld), .first_err_ch(first_err_ch),
        .first_err_code(first_err_code), .first_err_cyc(first_err_cyc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] wr_cnt;
        logic [95:0] dec_cnt;
        logic [2:0]  err;
        logic        fv;
        logic [2:0]  fch;
        logic [1:0]  fcode;
        logic [31:0] fcyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int          m_prev[3];
    bit          m_vld[3];
    int          m_bal[3];
    int          m_tmr[3];
    longint      m_wr[3];
    longint      m_dec[3];
    bit   [2:0]  m_err;
    bit          m_fv;
    int          m_fch;
    int          m_fcode;
    logic [31:0] m_fcyc;
    logic [31:0] m_cyc;

    // Stimulus-side remaining counters and outstanding writes per channel
    int lc[3];
    int owe[3];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_prev[c] = 0; m_vld[c] = 0; m_bal[c] = 0; m_tmr[c] = 0;
            m_wr[c] = 0; m_dec[c] = 0;
        end
        m_err = '0; m_fv = 0; m_fch = 0; m_fcode = 0; m_fcyc = '0; m_cyc = '0;
    endfunction

    function automatic void model_step(bit rst, bit en, bit cl, bit [2:0] wr);
        int code[3];
        int dec;
        int diff;
        int old_bal;
        if (!rst || cl) begin
            model_reset();
            return;
        end
        if (!en) return;
        for (int c = 0; c < 3; c++) begin
            dec = 0;
            code[c] = 0;
            if (!m_vld[c]) begin
                m_vld[c] = 1;
            end else begin
                diff = m_prev[c] - lc[c];
                if (diff < 0) begin
                    m_bal[c] = 0;
                    m_tmr[c] = 0;
                end else if (diff == 1) begin
                    dec = 1;
                end else if (diff > 1) begin
                    code[c] = 2;
                end
            end
            m_prev[c] = lc[c];
            old_bal   = m_bal[c];
            m_bal[c]  = m_bal[c] + int'(wr[c]) - dec;
            if (code[c] == 0 && (m_bal[c] > LAG_TOL || m_bal[c] < -LAG_TOL)) code[c] = 1;
            if (m_bal[c] == 0) m_tmr[c] = 0;
            else if (old_bal != 0) m_tmr[c]++;
            if (code[c] == 0 && m_tmr[c] == LAG_CYC) code[c] = 3;
            if (wr[c] && m_wr[c] < 64'hFFFF_FFFF) m_wr[c]++;
            if (dec == 1 && m_dec[c] < 64'hFFFF_FFFF) m_dec[c]++;
            if (code[c] != 0) m_err[c] = 1;
        end
        if (!m_fv) begin
            for (int c = 0; c < 3; c++) begin
                if (code[c] != 0) begin
                    m_fv = 1; m_fch = c; m_fcode = code[c]; m_fcyc = m_cyc;
                    break;
                end
            end
        end
        m_cyc = m_cyc + 32'd1;
    endfunction

    task automatic drive(input bit rst, input bit en, input bit cl, input bit [2:0] wr);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        mon_en   = en;
        clr      = cl;
        wr_en    = wr;
        left_cnt = {CNT_W'(lc[2]), CNT_W'(lc[1]), CNT_W'(lc[0])};
        model_step(rst, en, cl, wr);
        e.wr_cnt  = {m_wr[2][31:0], m_wr[1][31:0], m_wr[0][31:0]};
        e.dec_cnt = {m_dec[2][31:0], m_dec[1][31:0], m_dec[0][31:0]};
        e.err     = m_err;
        e.fv      = m_fv;
        e.fch     = 3'(m_fch);
        e.fcode   = 2'(m_fcode);
        e.fcyc    = m_fcyc;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every registered output update is compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_wr_cnt", wr_cnt, e.wr_cnt);
                check("sb_dec_cnt", dec_cnt, e.dec_cnt);
                check("sb_err_vec", err_vec, e.err);
                check("sb_first_vld", first_err_vld, e.fv);
                check("sb_first_ch", first_err_ch, e.fch);
                check("sb_first_code", first_err_code, e.fcode);
                check("sb_first_cyc", first_err_cyc, e.fcyc);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [2:0] w;
        bit       rst;
        bit       en;
        int       chaos;
        int       r;

        rst_n = 1'b0; mon_en = 1'b0; clr = 1'b0; wr_en = '0; left_cnt = '0;
        lc  = '{100, 40, 300};
        owe = '{0, 0, 0};
        model_reset();
        repeat (3) drive(0, 0, 0, 3'b000);
        settle();
        check("reset_err_vec", err_vec, 0);
        check("reset_wr_cnt", wr_cnt, 0);

        // T1 on ch0 (writes then unit decrements), T2 jump on ch1 at cycle 20
        for (int s = 0; s <= 20; s++) begin
            w = '0;
            if (s >= 1 && s <= 9 && (s % 2) == 1) w[0] = 1'b1;
            if (s >= 2 && s <= 10 && (s % 2) == 0) lc[0]--;
            if (s == 20) lc[1] = 37;
            drive(1, 1, 0, w);
            if (s == 19) begin
                settle();
                check("t1_err_vec", err_vec, 0);
            end
        end
        settle();
        check("t1_wr_cnt0", wr_cnt[31:0], 5);
        check("t1_dec_cnt0", dec_cnt[31:0], 5);
        check("t2_err_vec", err_vec, 3'b010);
        check("t2_first_vld", first_err_vld, 1);
        check("t2_first_code", first_err_code, 2);
        check("t2_first_ch", first_err_ch, 1);
        check("t2_first_cyc", first_err_cyc, 20);

        // T3a: three unmatched writes on ch2
        drive(1, 1, 1, 3'b000);
        lc = '{500, 600, 700};
        drive(1, 1, 0, 3'b000);
        drive(1, 1, 0, 3'b100);
        drive(1, 1, 0, 3'b100);
        settle();
        check("t3_tol_ok", err_vec, 0);
        drive(1, 1, 0, 3'b100);
        settle();
        check("t3_imbal_err", err_vec, 3'b100);
        check("t3_imbal_code", first_err_code, 1);
        check("t3_imbal_ch", first_err_ch, 2);
        check("t3_imbal_cyc", first_err_cyc, 3);

        // T3b: one write, no decrement for LAG_CYC cycles
        drive(1, 1, 1, 3'b000);
        drive(1, 1, 0, 3'b000);
        drive(1, 1, 0, 3'b100);
        repeat (7) drive(1, 1, 0, 3'b000);
        settle();
        check("t3_stale_early", err_vec, 0);
        drive(1, 1, 0, 3'b000);
        settle();
        check("t3_stale_err", err_vec, 3'b100);
        check("t3_stale_code", first_err_code, 3);
        check("t3_stale_cyc", first_err_cyc, 9);

        // T4: reload with pending balance, then matched same-cycle pairs
        drive(1, 1, 1, 3'b000);
        lc[0] = 0;
        drive(1, 1, 0, 3'b001);
        lc[0] = 500;
        drive(1, 1, 0, 3'b000);
        for (int i = 0; i < 10; i++) begin
            lc[0]--;
            drive(1, 1, 0, 3'b001);
        end
        settle();
        check("t4_err_vec", err_vec, 0);
        check("t4_first_vld", first_err_vld, 0);
        check("t4_wr_cnt0", wr_cnt[31:0], 11);
        check("t4_dec_cnt0", dec_cnt[31:0], 10);

        // T5: ch0 jump and ch2 imbalance at the same edge
        drive(1, 1, 1, 3'b000);
        lc[0] = 200; lc[2] = 50;
        drive(1, 1, 0, 3'b000);
        drive(1, 1, 0, 3'b100);
        drive(1, 1, 0, 3'b100);
        lc[0] = 190;
        drive(1, 1, 0, 3'b100);
        settle();
        check("t5_err_vec", err_vec, 3'b101);
        check("t5_first_ch", first_err_ch, 0);
        check("t5_first_code", first_err_code, 2);
        check("t5_first_cyc", first_err_cyc, 3);

        // T6: clr beats mon_en = 0; freeze; reset mid-stream re-primes
        drive(1, 0, 1, 3'b000);
        settle();
        check("t6_clr_wr_cnt", wr_cnt, 0);
        check("t6_clr_err_vec", err_vec, 0);
        check("t6_clr_first_vld", first_err_vld, 0);
        check("t6_clr_first_cyc", first_err_cyc, 0);
        lc[0] = 81;
        drive(1, 1, 0, 3'b000);
        drive(1, 1, 0, 3'b001);
        drive(1, 0, 0, 3'b001);
        settle();
        check("t6_hold_wr_cnt0", wr_cnt[31:0], 1);
        lc[0] = 80;
        drive(0, 1, 0, 3'b001);
        settle();
        check("t6_rst_wr_cnt", wr_cnt, 0);
        check("t6_rst_err_vec", err_vec, 0);
        drive(1, 1, 0, 3'b000);
        settle();
        check("t6_prime_dec_cnt0", dec_cnt[31:0], 0);
        lc[0] = 79;
        drive(1, 1, 0, 3'b000);
        settle();
        check("t6_post_dec_cnt0", dec_cnt[31:0], 1);

        // Randomized traffic with increasing fault injection
        lc  = '{5000, 6000, 7000};
        owe = '{0, 0, 0};
        for (int seg = 0; seg < 16; seg++) begin
            chaos = seg % 4;
            drive(1, 1'($urandom % 2), 1, 3'b000);
            for (int n = 0; n < 180; n++) begin
                rst = ($urandom % 400) != 0;
                en  = ($urandom % 12) != 0;
                for (int c = 0; c < 3; c++) begin
                    w[c] = ($urandom % 100) < 35;
                    r = int'($urandom % 1000);
                    if (r < chaos * 6) begin
                        lc[c] -= 2 + int'($urandom % 4);
                    end else if (r < chaos * 12 && lc[c] < 14000) begin
                        lc[c] += 1 + int'($urandom % 300);
                        owe[c] = 0;
                    end else if (r < chaos * 20) begin
                        lc[c]--;
                    end else if (r < chaos * 30) begin
                        // stall: hold the counter this cycle
                    end else if (owe[c] > 0 && ($urandom % 100) < 85) begin
                        lc[c]--;
                        owe[c]--;
                    end
                    if (w[c]) owe[c]++;
                    if (lc[c] < 8) begin
                        lc[c]  = 1000 + int'($urandom % 1000);
                        owe[c] = 0;
                    end
                end
                drive(rst, en, 0, w);
            end
        end

        settle();
        settle();
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
